// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage of the encryption pipeline.
package mem_stage_pkg;

  localparam int MEMO_LINES = 64;
  localparam int REGI_SIZE  = 16;
  localparam int VECT_SIZE  = 8;
  localparam int ELEM_SIZE  = 8;

  localparam int INT_BEATS = REGI_SIZE / ELEM_SIZE;
  localparam int VEC_BEATS = VECT_SIZE;
  localparam int ADDR_W    = $clog2(MEMO_LINES);
  localparam int CNT_W     = $clog2(VECT_SIZE + 1);
  localparam int IDX_W     = $clog2(VECT_SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } stage_state_e;

  // Number of element beats an access needs for the given operand kind.
  function automatic logic [CNT_W-1:0] beatCount(input logic vecSel);
    return vecSel ? CNT_W'(VEC_BEATS) : CNT_W'(INT_BEATS);
  endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// Private single-port data memory: MEMO_LINES x ELEM_SIZE, synchronous read.
// The array itself has no reset; only the read register is cleared.
module data_mem
  import mem_stage_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [ELEM_SIZE-1:0] wdata_i,
  output logic [ELEM_SIZE-1:0] rdata_o
);

  logic [ELEM_SIZE-1:0] memArray_r [MEMO_LINES];

  // Array write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      memArray_r[addr_i] <= wdata_i;
    end
  end

  // Registered read port, data available the cycle after the address.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_o <= {ELEM_SIZE{1'b0}};
    end else begin
      rdata_o <= memArray_r[addr_i];
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: scalar/vector loads and stores as beat-sequenced transfers
// against a private data memory, results registered to writeback.
// Optional feature macro: MEMSTAGE_BOUNDS_CHECK_EN (out-of-range elements are
// dropped/zeroed and flagged on mem_fault_o instead of wrapping).
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [REGI_SIZE-1:0]           ialu_res_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] valu_res_i,
  input  logic [REGI_SIZE-1:0]           iswa_res_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] vswa_res_i,
  input  logic                           enableMem_i,
  input  logic                           enableReg_i,
  input  logic                           enableJump_i,
  input  logic                           flagMemRead_i,
  input  logic                           flagMemWrite_i,
  input  logic                           vec_sel_i,
  input  logic                           swap_sel_i,
  output logic                           stall_o,
  output logic [REGI_SIZE-1:0]           int_wb_o,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] vec_wb_o,
  output logic                           enableReg_o,
  output logic                           enableJump_o,
  output logic                           vec_sel_o,
  output logic                           mem_fault_o
);

  localparam int INT_IDX_W = (INT_BEATS > 1) ? $clog2(INT_BEATS) : 1;

  stage_state_e                         state_r;
  stage_state_e                         nextState_s;
  logic [CNT_W-1:0]                     beatCnt_r;
  logic [VECT_SIZE-1:0][ELEM_SIZE-1:0]  asm_r;
  logic [VECT_SIZE-1:0][ELEM_SIZE-1:0]  loadVec_s;
  logic [VECT_SIZE-1:0][ELEM_SIZE-1:0]  vswaElems_s;
  logic [INT_BEATS-1:0][ELEM_SIZE-1:0]  iswaElems_s;
  logic [REGI_SIZE-1:0]                 intLoad_s;
  logic [CNT_W-1:0]                     nBeats_s;
  logic [CNT_W-1:0]                     lastBeat_s;
  logic [ADDR_W-1:0]                    base_s;
  logic [ADDR_W-1:0]                    memAddr_s;
  logic [IDX_W-1:0]                     elemIdx_s;
  logic [IDX_W-1:0]                     capIdx_s;
  logic [ELEM_SIZE-1:0]                 storeElem_s;
  logic [ELEM_SIZE-1:0]                 rdData_s;
  logic [ELEM_SIZE-1:0]                 capWord_s;
  logic memReq_s, isWrite_s, isRead_s, issue_s, stall_s, complete_s, memWe_s, oob_s;

  assign memReq_s    = enableMem_i & (flagMemRead_i | flagMemWrite_i);
  assign isWrite_s   = memReq_s & flagMemWrite_i;
  assign isRead_s    = memReq_s & ~flagMemWrite_i;
  assign nBeats_s    = beatCount(vec_sel_i);
  assign lastBeat_s  = nBeats_s - CNT_W'(1);
  assign base_s      = ialu_res_i[ADDR_W-1:0];
  assign elemIdx_s   = IDX_W'(beatCnt_r);
  assign capIdx_s    = IDX_W'(beatCnt_r - CNT_W'(1));
  assign vswaElems_s = vswa_res_i;
  assign iswaElems_s = iswa_res_i;
  assign storeElem_s = vec_sel_i ? vswaElems_s[elemIdx_s]
                                 : iswaElems_s[INT_IDX_W'(beatCnt_r)];

`ifdef MEMSTAGE_BOUNDS_CHECK_EN
  localparam int SUM_W = ADDR_W + 1;
  logic [SUM_W-1:0] addrSum_s;
  logic [SUM_W-1:0] lastSum_s;
  logic             rdOob_r;
  logic             opOob_s;
  assign addrSum_s = {1'b0, base_s} + SUM_W'(beatCnt_r);
  assign lastSum_s = {1'b0, base_s} + SUM_W'(lastBeat_s);
  assign memAddr_s = addrSum_s[ADDR_W-1:0];
  assign oob_s     = addrSum_s[ADDR_W];
  assign opOob_s   = memReq_s & lastSum_s[ADDR_W];
  assign capWord_s = rdOob_r ? {ELEM_SIZE{1'b0}} : rdData_s;
`else
  assign memAddr_s   = base_s + ADDR_W'(beatCnt_r);
  assign oob_s       = 1'b0;
  assign capWord_s   = rdData_s;
  assign mem_fault_o = 1'b0;
`endif

  assign memWe_s   = issue_s & isWrite_s & ~oob_s;
  assign stall_o   = rst_i & stall_s;
  assign intLoad_s = loadVec_s[INT_BEATS-1:0];

  // Merge the word returning this cycle into the assembled load data.
  always_comb begin
    loadVec_s           = asm_r;
    loadVec_s[capIdx_s] = capWord_s;
  end

  // Beat sequencing: decide stall, completion and next state.
  always_comb begin
    nextState_s = state_r;
    issue_s     = 1'b0;
    stall_s     = 1'b0;
    complete_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (memReq_s) begin
          issue_s = 1'b1;
          if (isRead_s || (nBeats_s > CNT_W'(1))) begin
            stall_s     = 1'b1;
            nextState_s = XFER;
          end else begin
            complete_s  = 1'b1;
            nextState_s = IDLE;
          end
        end else begin
          complete_s  = 1'b1;
          nextState_s = IDLE;
        end
      end
      XFER: begin
        issue_s = 1'b1;
        if (isWrite_s) begin
          if (beatCnt_r == lastBeat_s) begin
            complete_s  = 1'b1;
            nextState_s = IDLE;
          end else begin
            stall_s = 1'b1;
          end
        end else begin
          stall_s = 1'b1;
          if (beatCnt_r == lastBeat_s) begin
            nextState_s = DONE;
          end else begin
            nextState_s = XFER;
          end
        end
      end
      DONE: begin
        complete_s  = 1'b1;
        nextState_s = IDLE;
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // FSM state, beat counter, load assembly and registered writeback outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r      <= IDLE;
      beatCnt_r    <= {CNT_W{1'b0}};
      asm_r        <= {(VECT_SIZE*ELEM_SIZE){1'b0}};
      int_wb_o     <= {REGI_SIZE{1'b0}};
      vec_wb_o     <= {(VECT_SIZE*ELEM_SIZE){1'b0}};
      enableReg_o  <= 1'b0;
      enableJump_o <= 1'b0;
      vec_sel_o    <= 1'b0;
`ifdef MEMSTAGE_BOUNDS_CHECK_EN
      rdOob_r      <= 1'b0;
      mem_fault_o  <= 1'b0;
`endif
    end else begin
      state_r <= nextState_s;
`ifdef MEMSTAGE_BOUNDS_CHECK_EN
      rdOob_r <= oob_s;
`endif
      if ((state_r != IDLE) && isRead_s) begin
        asm_r <= loadVec_s;
      end
      if (complete_s) begin
        beatCnt_r    <= {CNT_W{1'b0}};
        int_wb_o     <= (isRead_s && !vec_sel_i) ? intLoad_s
                        : (swap_sel_i ? iswa_res_i : ialu_res_i);
        vec_wb_o     <= (isRead_s && vec_sel_i) ? loadVec_s
                        : (swap_sel_i ? vswa_res_i : valu_res_i);
        enableReg_o  <= enableReg_i;
        enableJump_o <= enableJump_i;
        vec_sel_o    <= vec_sel_i;
`ifdef MEMSTAGE_BOUNDS_CHECK_EN
        mem_fault_o  <= mem_fault_o | opOob_s;
`endif
      end else begin
        beatCnt_r    <= beatCnt_r + CNT_W'(1);
        enableReg_o  <= 1'b0;
        enableJump_o <= 1'b0;
      end
    end
  end

  data_mem uMem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (memWe_s),
    .addr_i  (memAddr_s),
    .wdata_i (storeElem_s),
    .rdata_o (rdData_s)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver pushes expected writeback per op,
// a monitor pops and compares on every completing edge.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [15:0] ialu = 16'h0, iswa = 16'h0;
  logic [63:0] valu = 64'h0, vswa = 64'h0;
  logic        enMem = 1'b0, enReg = 1'b0, enJmp = 1'b0, rd = 1'b0, wr = 1'b0;
  logic        vecSel = 1'b0, swp = 1'b0;
  logic        stall_o, enableReg_o, enableJump_o, vec_sel_o, mem_fault_o;
  logic [15:0] int_wb_o;
  logic [63:0] vec_wb_o;

  typedef struct {
    string       name;
    logic [15:0] intWb;
    logic [63:0] vecWb;
    logic        enReg;
    logic        enJmp;
    logic        vecSel;
    logic        fault;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  logic presenting = 1'b0;

`ifdef MEMSTAGE_BOUNDS_CHECK_EN
  localparam int VEC_BASE = 40;
`else
  localparam int VEC_BASE = 60;
`endif
  localparam int LD_BASE = (VEC_BASE + 4) % 64;

  mem_stage dut (
    .clk_i(clk), .rst_i(rst_i),
    .ialu_res_i(ialu), .valu_res_i(valu), .iswa_res_i(iswa), .vswa_res_i(vswa),
    .enableMem_i(enMem), .enableReg_i(enReg), .enableJump_i(enJmp),
    .flagMemRead_i(rd), .flagMemWrite_i(wr),
    .vec_sel_i(vecSel), .swap_sel_i(swp),
    .stall_o(stall_o), .int_wb_o(int_wb_o), .vec_wb_o(vec_wb_o),
    .enableReg_o(enableReg_o), .enableJump_o(enableJump_o),
    .vec_sel_o(vec_sel_o), .mem_fault_o(mem_fault_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chkMem(input int a, input logic [7:0] v);
    chk($sformatf("mem[%0d]", a), 64'(dut.uMem.memArray_r[a]), 64'(v));
  endtask

  // Called 2 time units after a rising edge; returns at the same phase.
  task automatic runOp(input string name, input logic m, input logic r, input logic w,
                       input logic v, input logic s, input logic er, input logic ej,
                       input logic [15:0] ia, input logic [15:0] is,
                       input logic [63:0] va, input logic [63:0] vs,
                       input int expStall, input logic [15:0] expInt,
                       input logic [63:0] expVec, input logic expFault);
    exp_t e;
    int   stallCycles = 0;
    bit   done = 1'b0;
    logic st;
    enMem = m; rd = r; wr = w; vecSel = v; swp = s; enReg = er; enJmp = ej;
    ialu = ia; iswa = is; valu = va; vswa = vs;
    e.name = name; e.intWb = expInt; e.vecWb = expVec; e.enReg = er;
    e.enJmp = ej; e.vecSel = v; e.fault = expFault;
    expQ.push_back(e);
    presenting = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      st = stall_o;
      @(posedge clk);
      #2;
      if (st) begin
        stallCycles++;
        if (c == 0) chk({name, " bubble enableReg_o"}, 64'(enableReg_o), 64'd0);
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL %s: timeout, op never completed", name);
    end
    chk({name, " stall cycles"}, 64'(stallCycles), 64'(expStall));
    presenting = 1'b0;
  endtask

  // Monitor: compare registered outputs after every completing edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (presenting && !stall_o) begin
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL monitor: completion with empty scoreboard");
        end else begin
          e = expQ.pop_front();
          chk({e.name, " int_wb_o"}, 64'(int_wb_o), 64'(e.intWb));
          chk({e.name, " vec_wb_o"}, vec_wb_o, e.vecWb);
          chk({e.name, " enableReg_o"}, 64'(enableReg_o), 64'(e.enReg));
          chk({e.name, " enableJump_o"}, 64'(enableJump_o), 64'(e.enJmp));
          chk({e.name, " vec_sel_o"}, 64'(vec_sel_o), 64'(e.vecSel));
          chk({e.name, " mem_fault_o"}, 64'(mem_fault_o), 64'(e.fault));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("reset int_wb_o", 64'(int_wb_o), 64'd0);
    chk("reset vec_wb_o", vec_wb_o, 64'd0);
    chk("reset stall_o", 64'(stall_o), 64'd0);
    chk("reset enableReg_o", 64'(enableReg_o), 64'd0);
    chk("reset mem_fault_o", 64'(mem_fault_o), 64'd0);
    @(posedge clk); #2; rst_i = 1'b1;

    // Integer store 0xBEEF to base 10, then load it back.
    runOp("int store", 1, 0, 1, 0, 0, 0, 0, 16'd10, 16'hBEEF, 64'h0, 64'h0,
          1, 16'h000A, 64'h0, 0);
    chkMem(10, 8'hEF); chkMem(11, 8'hBE);
    runOp("int load", 1, 1, 0, 0, 0, 1, 0, 16'd10, 16'h0, 64'h1111, 64'h0,
          2, 16'hBEEF, 64'h1111, 0);

    // Vector store / load around the top of memory.
    runOp("vec store", 1, 0, 1, 1, 0, 0, 0, 16'(VEC_BASE), 16'h0,
          64'h0123456789ABCDEF, 64'h0706050403020100,
          7, 16'(VEC_BASE), 64'h0123456789ABCDEF, 0);
    for (int i = 0; i < 8; i++) chkMem((VEC_BASE + i) % 64, 8'(i));
    runOp("vec load", 1, 1, 0, 1, 0, 1, 0, 16'(VEC_BASE), 16'h0, 64'h0, 64'h0,
          8, 16'(VEC_BASE), 64'h0706050403020100, 0);

    // Non-memory ops complete in one cycle.
    runOp("alu swap", 0, 0, 0, 0, 1, 1, 1, 16'h1234, 16'hABCD,
          64'h2222, 64'hCAFE0000BABE0000, 0, 16'hABCD, 64'hCAFE0000BABE0000, 0);
    runOp("mem no flags", 1, 0, 0, 0, 0, 1, 0, 16'h4321, 16'hABCD,
          64'h3333, 64'h4444, 0, 16'h4321, 64'h3333, 0);

    // Both flags set behaves as a store.
    runOp("rd+wr", 1, 1, 1, 0, 1, 1, 0, 16'd4, 16'h5A5A, 64'h0, 64'h0,
          1, 16'h5A5A, 64'h0, 0);
    chkMem(4, 8'h5A); chkMem(5, 8'h5A);

    // Reset during beat 3 of a vector load.
    enMem = 1; rd = 1; wr = 0; vecSel = 1; swp = 0; enReg = 1; enJmp = 0;
    ialu = 16'(VEC_BASE);
    repeat (3) @(posedge clk);
    #2; rst_i = 1'b0;
    #1;
    chk("midreset int_wb_o", 64'(int_wb_o), 64'd0);
    chk("midreset vec_wb_o", vec_wb_o, 64'd0);
    chk("midreset stall_o", 64'(stall_o), 64'd0);
    chk("midreset enableReg_o", 64'(enableReg_o), 64'd0);
    chk("midreset vec_sel_o", 64'(vec_sel_o), 64'd0);
    @(posedge clk); #2; rst_i = 1'b1;
    runOp("post-reset load", 1, 1, 0, 0, 0, 1, 0, 16'(LD_BASE), 16'h0,
          64'h55, 64'h0, 2, 16'h0504, 64'h55, 0);

`ifdef MEMSTAGE_BOUNDS_CHECK_EN
    runOp("seed 0", 1, 0, 1, 0, 0, 0, 0, 16'd0, 16'h2211, 64'h0, 64'h0,
          1, 16'h0000, 64'h0, 0);
    runOp("seed 2", 1, 0, 1, 0, 0, 0, 0, 16'd2, 16'h4433, 64'h0, 64'h0,
          1, 16'h0002, 64'h0, 0);
    runOp("oob store", 1, 0, 1, 1, 0, 0, 0, 16'd62, 16'h0, 64'h77,
          64'h1716151413121110, 7, 16'd62, 64'h77, 1);
    chkMem(62, 8'h10); chkMem(63, 8'h11);
    chkMem(0, 8'h11); chkMem(1, 8'h22); chkMem(2, 8'h33);
    chkMem(3, 8'h44); chkMem(4, 8'h5A); chkMem(5, 8'h5A);
    runOp("oob load", 1, 1, 0, 1, 0, 1, 0, 16'd62, 16'h0, 64'h0, 64'h0,
          8, 16'd62, 64'h0000000000001110, 1);
    runOp("fault sticky", 0, 0, 0, 0, 0, 1, 0, 16'h0101, 16'h0, 64'h9, 64'h0,
          0, 16'h0101, 64'h9, 1);
    rst_i = 1'b0; #1;
    chk("fault cleared by reset", 64'(mem_fault_o), 64'd0);
    @(posedge clk); #2; rst_i = 1'b1;
`endif

    enMem = 0; rd = 0; wr = 0;
    repeat (2) @(posedge clk);
    chk("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
